// File: rtl/acc_req_arbiter_pkg.sv
// Shared constants, contribution record and flat-index helpers for the accumulator request arbiter.
// Optional build macro ACC_ARB_FIXED_PRIO_EN (fixed priority) is consumed by the picker and the top.
package acc_req_arbiter_pkg;

  localparam int N_CORE = 4;
  localparam int N_ACC  = 2;
  localparam int DATA_W = 32;
  localparam int N_REQ  = N_CORE * N_ACC;

  localparam int ACC_W  = (N_ACC  > 1) ? $clog2(N_ACC)  : 1;
  localparam int CORE_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;
  localparam int REQ_W  = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;
  localparam int CNT_W  = $clog2(N_CORE) + 1;

  typedef logic [ACC_W-1:0]  acc_idx_t;
  typedef logic [CORE_W-1:0] core_idx_t;
  typedef logic [REQ_W-1:0]  req_idx_t;
  typedef logic [CNT_W-1:0]  acc_cnt_t;

  typedef struct packed {
    acc_idx_t          acc;
    core_idx_t         core;
    logic [DATA_W-1:0] data;
  } acc_contrib_t;

  // Flat request index is core*N_ACC + acc.
  function automatic acc_idx_t acc_of(input req_idx_t idx);
    return ACC_W'(int'(idx) % N_ACC);
  endfunction

  function automatic core_idx_t core_of(input req_idx_t idx);
    return CORE_W'(int'(idx) / N_ACC);
  endfunction

endpackage

// File: rtl/acc_req_arbiter_if.sv
// Request-side and output-side bundle between the cores, the arbiter and the parent accumulate unit.
// Not affected by ACC_ARB_FIXED_PRIO_EN.
interface acc_req_arbiter_if;
  import acc_req_arbiter_pkg::*;

  // Handshake: a transfer happens on a cycle where valid && ready. Valid must not
  // depend on ready; a requester may withdraw valid before it sees ready.
  logic [N_CORE-1:0][N_ACC-1:0]             acc_req_valid;
  logic [N_CORE-1:0][N_ACC-1:0]             acc_req_ready;
  logic [N_CORE-1:0][N_ACC-1:0][DATA_W-1:0] acc_data;
  logic                                     out_valid;
  logic                                     out_ready;
  acc_idx_t                                 out_acc;
  core_idx_t                                out_core;
  logic [DATA_W-1:0]                        out_data;
  logic                                     clear;
  logic [N_ACC-1:0][CNT_W-1:0]              acc_cnt;

  modport slave (
    input  acc_req_valid, acc_data, out_ready, clear,
    output acc_req_ready, out_valid, out_acc, out_core, out_data, acc_cnt
  );

  modport master (
    output acc_req_valid, acc_data, out_ready, clear,
    input  acc_req_ready, out_valid, out_acc, out_core, out_data, acc_cnt
  );

endinterface

// File: rtl/acc_req_arbiter_rr_picker.sv
// Combinational first-set-at-or-after-pointer picker with wrap; one-hot grant plus binary index.
// With ACC_ARB_FIXED_PRIO_EN defined the pointer is ignored and the lowest index wins.
module acc_req_arbiter_rr_picker #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef ACC_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    int   start;
    int   j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
`ifdef ACC_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = int'(ptr_i);
`endif
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/acc_req_arbiter.sv
// Parent-side arbiter: grants one core/accumulator request per cycle into a registered output
// stage and counts delivered contributions per accumulator. ACC_ARB_FIXED_PRIO_EN selects fixed priority.
module acc_req_arbiter
  import acc_req_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  acc_req_arbiter_if.slave  bus
);

  logic [N_REQ-1:0]            req_vec;
  logic [N_REQ-1:0]            gnt_vec;
  req_idx_t                    gnt_idx;
  req_idx_t                    ptr;
  req_idx_t                    next_ptr;
  logic                        gnt_any;
  logic                        stage_free;
  logic                        consume;

  logic                        out_valid_q, out_valid_d;
  acc_contrib_t                out_q, out_d;
  logic [N_ACC-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign stage_free = !out_valid_q || bus.out_ready;
  assign consume    = out_valid_q && bus.out_ready;

  // Ready is purely combinational from valid, so reset must mask it explicitly.
  assign req_vec = (rst_n && stage_free) ? bus.acc_req_valid : '0;

  acc_req_arbiter_rr_picker #(
    .N     (N_REQ),
    .IDX_W (REQ_W)
  ) u_picker (
    .req_i (req_vec),
    .ptr_i (ptr),
    .gnt_o (gnt_vec),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign bus.acc_req_ready = gnt_vec;
  assign next_ptr = (gnt_idx == REQ_W'(N_REQ - 1)) ? '0 : gnt_idx + REQ_W'(1);

`ifdef ACC_ARB_FIXED_PRIO_EN
  assign ptr = '0;
  logic unused_next_ptr;
  assign unused_next_ptr = ^next_ptr;
`else
  req_idx_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (bus.clear) begin
      ptr_d = '0;
    end else if (gnt_any) begin
      ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    if (gnt_any) begin
      out_valid_d = 1'b1;
      out_d.acc   = acc_of(gnt_idx);
      out_d.core  = core_of(gnt_idx);
      out_d.data  = bus.acc_data[core_of(gnt_idx)][acc_of(gnt_idx)];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // Clear wins over a same-cycle consume, so that contribution is not counted.
    if (bus.clear) begin
      cnt_d = '0;
    end else if (consume && (cnt_q[out_q.acc] != CNT_W'(N_CORE))) begin
      cnt_d[out_q.acc] = cnt_q[out_q.acc] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_q.acc;
  assign bus.out_core  = out_q.core;
  assign bus.out_data  = out_q.data;
  assign bus.acc_cnt   = cnt_q;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed table-driven bench for acc_req_arbiter; ACC_ARB_FIXED_PRIO_EN selects the fixed-priority sequence.
module tb_acc_req_arbiter;
  import acc_req_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  acc_req_arbiter_if bus ();

  acc_req_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [7:0]  valid;
    logic        ordy;
    logic        clr;
    logic [7:0]  ready;
    logic        ov;
    logic        chk;
    logic [1:0]  core;
    logic        acc;
    logic [31:0] data;
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic logic [31:0] data_of(input int c, input int a);
    return 32'hA5A5_0000 + 32'(c) * 32'h100 + 32'(a);
  endfunction

  task automatic add(input logic rst, input logic [7:0] valid, input logic ordy, input logic clr,
                     input logic [7:0] ready, input logic ov, input int core, input int acc,
                     input int cnt0, input int cnt1);
    vec_t v;
    v.rst   = rst;
    v.valid = valid;
    v.ordy  = ordy;
    v.clr   = clr;
    v.ready = ready;
    v.ov    = ov;
    v.chk   = ov || !rst;
    v.core  = 2'(core);
    v.acc   = 1'(acc);
    v.data  = rst ? data_of(core, acc) : 32'h0;
    v.cnt0  = 3'(cnt0);
    v.cnt1  = 3'(cnt1);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic drive(input logic rst, input logic [7:0] valid, input logic ordy, input logic clr);
    @(negedge clk);
    rst_n             = rst;
    bus.acc_req_valid = valid;
    bus.out_ready     = ordy;
    bus.clear         = clr;
    #1;
  endtask

  task automatic check_stage(input string tag, input int core, input int acc, input logic [31:0] data);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".out_core"},  32'(bus.out_core),  32'(core));
    check({tag, ".out_acc"},   32'(bus.out_acc),   32'(acc));
    check({tag, ".out_data"},  bus.out_data,       data);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.acc_req_valid = '0;
    bus.out_ready     = 1'b0;
    bus.clear         = 1'b0;
    for (int c = 0; c < N_CORE; c++)
      for (int a = 0; a < N_ACC; a++)
        bus.acc_data[c][a] = data_of(c, a);

`ifdef ACC_ARB_FIXED_PRIO_EN
    drive(1'b0, 8'hFF, 1'b1, 1'b0);
    check("fx_rst.ready", 32'(bus.acc_req_ready), 32'h0);
    check("fx_rst.out_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h22, 1'b1, 1'b0);
      check($sformatf("fx_hold%0d.ready", i), 32'(bus.acc_req_ready), 32'h02);
    end
    drive(1'b1, 8'h20, 1'b1, 1'b0);
    check("fx_drop.ready", 32'(bus.acc_req_ready), 32'h20);
    check_stage("fx_drop", 0, 1, data_of(0, 1));
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    check_stage("fx_last", 2, 1, data_of(2, 1));
`else
    // rst valid ordy clr | ready ov core acc cnt0 cnt1
    add(0, 8'hFF, 1, 0,  8'h00, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 1, 0,  8'h01, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 1, 0,  8'h02, 1, 0, 0, 0, 0);
    add(1, 8'hFF, 1, 0,  8'h04, 1, 0, 1, 1, 0);
    add(1, 8'hFF, 1, 0,  8'h08, 1, 1, 0, 1, 1);
    add(1, 8'hFF, 1, 0,  8'h10, 1, 1, 1, 2, 1);
    add(1, 8'hFF, 1, 0,  8'h20, 1, 2, 0, 2, 2);
    add(1, 8'hFF, 1, 0,  8'h40, 1, 2, 1, 3, 2);
    add(1, 8'hFF, 1, 0,  8'h80, 1, 3, 0, 3, 3);
    add(1, 8'hFF, 1, 0,  8'h01, 1, 3, 1, 4, 3);
    add(1, 8'hFF, 1, 0,  8'h02, 1, 0, 0, 4, 4);
    add(1, 8'hFF, 1, 0,  8'h04, 1, 0, 1, 4, 4);
    add(1, 8'h00, 1, 0,  8'h00, 1, 1, 0, 4, 4);
    add(1, 8'h00, 0, 1,  8'h00, 0, 0, 0, 4, 4);
    // wrap: steer pointer to 7, then 7 and 2 pending
    add(1, 8'h40, 1, 0,  8'h40, 0, 0, 0, 0, 0);
    add(1, 8'h84, 1, 0,  8'h80, 1, 3, 0, 0, 0);
    add(1, 8'h04, 1, 0,  8'h04, 1, 3, 1, 1, 0);
    add(1, 8'h00, 0, 0,  8'h00, 1, 1, 0, 1, 1);
    // build acc_cnt[0]=3, then clear collides with a consume of acc 0
    add(1, 8'h01, 1, 0,  8'h01, 1, 1, 0, 1, 1);
    add(1, 8'h01, 1, 0,  8'h01, 1, 0, 0, 2, 1);
    add(1, 8'h01, 1, 1,  8'h01, 1, 0, 0, 3, 1);
    add(1, 8'h00, 0, 0,  8'h00, 1, 0, 0, 0, 0);
    add(1, 8'h03, 1, 0,  8'h01, 1, 0, 0, 0, 0);
    add(1, 8'h00, 1, 0,  8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0,  8'h00, 0, 0, 0, 2, 0);
    // reset mid-operation discards the stage and returns the pointer to 0
    add(1, 8'h10, 0, 0,  8'h10, 0, 0, 0, 2, 0);
    add(0, 8'hFF, 1, 0,  8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h21, 1, 0,  8'h01, 0, 0, 0, 0, 0);
    add(1, 8'h00, 1, 0,  8'h00, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].ordy, vecs[i].clr);
      check($sformatf("v%0d.ready", i),     32'(bus.acc_req_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d.out_valid", i), 32'(bus.out_valid),     32'(vecs[i].ov));
      check($sformatf("v%0d.acc_cnt0", i),  32'(bus.acc_cnt[0]),    32'(vecs[i].cnt0));
      check($sformatf("v%0d.acc_cnt1", i),  32'(bus.acc_cnt[1]),    32'(vecs[i].cnt1));
      if (vecs[i].chk) begin
        check($sformatf("v%0d.out_core", i), 32'(bus.out_core), 32'(vecs[i].core));
        check($sformatf("v%0d.out_acc", i),  32'(bus.out_acc),  32'(vecs[i].acc));
        check($sformatf("v%0d.out_data", i), bus.out_data,      vecs[i].data);
      end
    end

    // Back-pressure: one grant to (2,1), then the stage holds while out_ready is low.
    bus.acc_data[2][1] = 32'hDEADBEEF;
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    check("bp_grant.ready", 32'(bus.acc_req_ready), 32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h20, 1'b0, 1'b0);
      check($sformatf("bp_hold%0d.ready", i), 32'(bus.acc_req_ready), 32'h0);
      check_stage($sformatf("bp_hold%0d", i), 2, 1, 32'hDEADBEEF);
      check($sformatf("bp_hold%0d.acc_cnt1", i), 32'(bus.acc_cnt[1]), 32'd0);
    end
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    check_stage("bp_release", 2, 1, 32'hDEADBEEF);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    check("bp_done.out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_done.acc_cnt1",  32'(bus.acc_cnt[1]), 32'd1);
    check("bp_done.acc_cnt0",  32'(bus.acc_cnt[0]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
